// File: rtl/count_seq_monitor_pkg.sv
// Shared types and default widths for the count sequence monitor.
// Illegal state encoding 2'd3 is folded back onto SYNC by decode_state.
package count_seq_monitor_pkg;

    localparam int CNT_W_DFLT  = 4;
    localparam int ROLL_W_DFLT = 8;
    localparam int ERR_W_DFLT  = 8;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2,
        ST_ILL   = 2'd3
    } state_e;

    function automatic state_e decode_state(input state_e s);
        return (s == ST_ILL) ? ST_SYNC : s;
    endfunction

endpackage

// File: rtl/count_seq_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; an increment on the
// clear edge leaves the count at one.
module count_seq_monitor_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {{(W-1){1'b0}}, inc_i};
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/count_seq_monitor.sv
// Checks that an upstream counter steps by +1 every clock, counts wraps.
// Define COUNT_SEQ_MON_ALLOW_HOLD_EN to accept a stalled (held) count.
module count_seq_monitor
    import count_seq_monitor_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DFLT,
    parameter int ROLL_W = ROLL_W_DFLT,
    parameter int ERR_W  = ERR_W_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  q,
    input  logic              cnt_reset,
    input  logic              clr_err,
    output logic              wrap_pulse,
    output logic [ROLL_W-1:0] wrap_count,
    output logic              seq_err,
    output logic [ERR_W-1:0]  err_count,
    output logic              in_sync,
    output logic [1:0]        state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             state_q, state_d, cur;
    logic [CNT_W-1:0]   q_prev_q, q_prev_d, expv;
    logic [1:0]         good_run_q, good_run_d;
    logic               wrap_pulse_q, wrap_pulse_d;
    logic [ROLL_W-1:0]  wrap_count_q, wrap_count_d;
    logic               seq_err_q, seq_err_d;
    logic               in_sync_q;
    logic               match, hold_ok, err_inc, clr;

    assign expv  = q_prev_q + 1'b1;
    assign match = (q == expv);
    assign cur   = decode_state(state_q);

`ifdef COUNT_SEQ_MON_ALLOW_HOLD_EN
    assign hold_ok = (q == q_prev_q);
`else
    assign hold_ok = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        q_prev_d     = q_prev_q;
        good_run_d   = good_run_q;
        wrap_pulse_d = 1'b0;
        wrap_count_d = wrap_count_q;
        err_inc      = 1'b0;
        if (cnt_reset) begin
            state_d      = ST_SYNC;
            wrap_count_d = '0;
        end else begin
            case (cur)
                ST_TRACK: begin
                    if (match) begin
                        q_prev_d = q;
                        if (q_prev_q == CNT_MAX) begin
                            wrap_pulse_d = 1'b1;
                            wrap_count_d = wrap_count_q + 1'b1;
                        end
                    end else if (!hold_ok) begin
                        err_inc    = 1'b1;
                        q_prev_d   = q;
                        good_run_d = '0;
                        state_d    = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    // Wraps seen while recovering are deliberately not counted.
                    if (match) begin
                        q_prev_d   = q;
                        good_run_d = good_run_q + 1'b1;
                        if (good_run_d == 2'd2) begin
                            state_d = ST_TRACK;
                        end
                    end else if (!hold_ok) begin
                        err_inc    = 1'b1;
                        q_prev_d   = q;
                        good_run_d = '0;
                    end
                end
                default: begin
                    q_prev_d = q;
                    state_d  = ST_TRACK;
                end
            endcase
        end
    end

    assign clr = clr_err && !cnt_reset;

    always_comb begin
        seq_err_d = seq_err_q;
        if (err_inc) begin
            seq_err_d = 1'b1;
        end else if (clr) begin
            seq_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_SYNC;
            q_prev_q     <= '0;
            good_run_q   <= '0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= '0;
            seq_err_q    <= 1'b0;
            in_sync_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_prev_q     <= q_prev_d;
            good_run_q   <= good_run_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_count_q <= wrap_count_d;
            seq_err_q    <= seq_err_d;
            in_sync_q    <= (state_d == ST_TRACK);
        end
    end

    count_seq_monitor_sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .inc_i   (err_inc),
        .clr_i   (clr),
        .count_o (err_count)
    );

    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;
    assign seq_err    = seq_err_q;
    assign in_sync    = in_sync_q;
    assign state      = state_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Scenario bench for count_seq_monitor: expected observations are queued
// as stimulus is driven and popped/compared on the following falling edge.
module tb_count_seq_monitor;

    typedef struct packed {
        logic [1:0] st;
        logic       wp;
        logic [7:0] wc;
        logic       se;
        logic [7:0] ec;
        logic       is;
    } obs_t;

    logic       clk = 1'b1;
    logic       reset = 1'b0;
    logic [3:0] q = 4'd0;
    logic       cnt_reset = 1'b0;
    logic       clr_err = 1'b0;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       seq_err;
    logic [7:0] err_count;
    logic       in_sync;
    logic [1:0] state;

    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];
    obs_t got, want;
    logic [3:0] cq;

    always #5 clk = ~clk;

    count_seq_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .q          (q),
        .cnt_reset  (cnt_reset),
        .clr_err    (clr_err),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .seq_err    (seq_err),
        .err_count  (err_count),
        .in_sync    (in_sync),
        .state      (state)
    );

    function automatic obs_t mk(logic [1:0] st, logic wp, logic [7:0] wc,
                                logic se, logic [7:0] ec);
        obs_t o;
        o.st = st; o.wp = wp; o.wc = wc;
        o.se = se; o.ec = ec; o.is = (st == 2'd1);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.wp = wrap_pulse; o.wc = wrap_count;
        o.se = seq_err; o.ec = err_count; o.is = in_sync;
        return o;
    endfunction

    // Drive at a falling edge, let the rising edge sample, return on the next falling edge.
    task automatic step(input logic [3:0] qv, input logic cr, input logic ce,
                        input obs_t e);
        q = qv; cnt_reset = cr; clr_err = ce;
        cq = qv;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        sb.push_back(mk(2'd0, 1'b0, 8'd0, 1'b0, 8'd0));
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset got %p want %p", got, want);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        logic [7:0] wc;
        wc = 8'd0;
        for (int i = 0; i < 20; i++) begin
            logic [3:0] v;
            logic wp;
            v  = 4'(i);
            wp = (i == 16);
            if (wp) wc = 8'd1;
            step(v, 1'b0, 1'b0, mk(2'd1, wp, wc, 1'b0, 8'd0));
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL wrap step %0d got %p want %p", i, got, want);
            end
        end
    endtask

    task automatic test_fault();
        logic [3:0] qs[5];
        obs_t es[5];
        qs = '{4'd4, 4'd6, 4'd7, 4'd8, 4'd9};
        es[0] = mk(2'd1, 1'b0, 8'd1, 1'b0, 8'd0);
        es[1] = mk(2'd2, 1'b0, 8'd1, 1'b1, 8'd1);
        es[2] = mk(2'd2, 1'b0, 8'd1, 1'b1, 8'd1);
        es[3] = mk(2'd1, 1'b0, 8'd1, 1'b1, 8'd1);
        es[4] = mk(2'd1, 1'b0, 8'd1, 1'b1, 8'd1);
        for (int i = 0; i < 5; i++) begin
            step(qs[i], 1'b0, 1'b0, es[i]);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL fault step %0d got %p want %p", i, got, want);
            end
        end
        for (int i = 10; i < 26; i++) begin
            logic [3:0] v;
            v = 4'(i);
            step(v, 1'b0, 1'b0,
                 mk(2'd1, (v == 4'd0), (i < 16) ? 8'd1 : 8'd2, 1'b1, 8'd1));
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL fault run q=%0d got %p want %p", v, got, want);
            end
        end
    endtask

    task automatic test_cnt_reset();
        step(4'd10, 1'b1, 1'b0, mk(2'd0, 1'b0, 8'd0, 1'b1, 8'd1));
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cnt_reset hit got %p want %p", got, want);
        end
        for (int i = 0; i < 3; i++) begin
            step(4'(i), 1'b0, 1'b0, mk(2'd1, 1'b0, 8'd0, 1'b1, 8'd1));
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL cnt_reset resync %0d got %p want %p", i, got, want);
            end
        end
    endtask

    task automatic test_clr_err();
        logic [3:0] qs[4];
        logic       cs[4];
        obs_t es[4];
        qs = '{4'd3, 4'd5, 4'd6, 4'd7};
        cs = '{1'b0, 1'b1, 1'b1, 1'b0};
        es[0] = mk(2'd1, 1'b0, 8'd0, 1'b1, 8'd1);
        es[1] = mk(2'd2, 1'b0, 8'd0, 1'b1, 8'd1);
        es[2] = mk(2'd2, 1'b0, 8'd0, 1'b0, 8'd0);
        es[3] = mk(2'd1, 1'b0, 8'd0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            step(qs[i], 1'b0, cs[i], es[i]);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL clr_err step %0d got %p want %p", i, got, want);
            end
        end
    endtask

    task automatic test_hold();
        logic [3:0] qs[5];
        logic       cs[5];
        obs_t es[5];
        qs = '{4'd7, 4'd7, 4'd8, 4'd9, 4'd10};
        cs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef COUNT_SEQ_MON_ALLOW_HOLD_EN
        es[0] = mk(2'd1, 1'b0, 8'd0, 1'b0, 8'd0);
        es[1] = mk(2'd1, 1'b0, 8'd0, 1'b0, 8'd0);
        es[2] = mk(2'd1, 1'b0, 8'd0, 1'b0, 8'd0);
        es[3] = mk(2'd1, 1'b0, 8'd0, 1'b0, 8'd0);
`else
        es[0] = mk(2'd2, 1'b0, 8'd0, 1'b1, 8'd1);
        es[1] = mk(2'd2, 1'b0, 8'd0, 1'b1, 8'd2);
        es[2] = mk(2'd2, 1'b0, 8'd0, 1'b1, 8'd2);
        es[3] = mk(2'd1, 1'b0, 8'd0, 1'b1, 8'd2);
`endif
        es[4] = mk(2'd1, 1'b0, 8'd0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            step(qs[i], 1'b0, cs[i], es[i]);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL hold step %0d got %p want %p", i, got, want);
            end
        end
    endtask

    task automatic test_wrap_rollover();
        int k;
        logic [3:0] v;
        k = 0;
        v = cq;
        while (k < 256 || v != 4'd1) begin
            logic wp;
            v  = v + 4'd1;
            wp = (v == 4'd0);
            if (wp) k++;
            step(v, 1'b0, 1'b0, mk(2'd1, wp, 8'(k), 1'b0, 8'd0));
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rollover wrap %0d q=%0d got %p want %p", k, v, got, want);
            end
        end
    endtask

    task automatic test_err_sat();
        logic [3:0] v;
        v = cq;
        for (int n = 1; n <= 300; n++) begin
            v = v + 4'd2;
            step(v, 1'b0, 1'b0,
                 mk(2'd2, 1'b0, 8'd0, 1'b1, (n > 255) ? 8'd255 : 8'(n)));
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL err_sat fault %0d got %p want %p", n, got, want);
            end
        end
        v = v + 4'd1;
        step(v, 1'b0, 1'b1, mk(2'd2, 1'b0, 8'd0, 1'b0, 8'd0));
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL err_sat clear got %p want %p", got, want);
        end
        v = v + 4'd1;
        step(v, 1'b0, 1'b0, mk(2'd1, 1'b0, 8'd0, 1'b0, 8'd0));
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL err_sat resync got %p want %p", got, want);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_fault();
        test_cnt_reset();
        test_clr_err();
        test_hold();
        test_wrap_rollover();
        test_err_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
